// File: rtl/dreg_arbiter.sv
// Round-robin arbiter that shares one W-bit register among N requesters.
// Optional held grants are enabled with the DREG_ARB_LOCK_EN macro.
module dreg_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   lock,
    input  logic [N*W-1:0] din,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] owner,
    output logic [W-1:0]   q,
    output logic           q_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [N-1:0]   gnt_nxt;
    logic [IDW-1:0] owner_nxt;
    logic [W-1:0]   q_nxt;
    logic           q_valid_nxt;

    logic [N-1:0]   elig;
    logic           win_found;
    logic [IDW-1:0] win;
    logic           held;

    logic [W-1:0]   din_arr [N];

    for (genvar i = 0; i < int'(N); i++) begin : g_unpack
        assign din_arr[i] = din[i*W +: W];
    end

`ifdef DREG_ARB_LOCK_EN
    // A grant is held only while its own owner keeps lock high.
    assign held = (state != IDLE) && lock[owner];
`else
    logic lock_unused;
    assign lock_unused = ^lock;
    assign held        = 1'b0;
`endif

    // Round-robin search starting at ptr; the current grantee is masked out.
    always_comb begin
        int idx;
        elig      = req & ~gnt;
        win_found = 1'b0;
        win       = '0;
        idx       = 0;
        for (int k = 0; k < int'(N); k++) begin
            idx = (int'(ptr) + k) % int'(N);
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win       = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        owner_nxt   = owner;
        ptr_nxt     = ptr;
        q_nxt       = q;
        q_valid_nxt = 1'b0;

        case (state)
            GRANT, LOCKED: begin
                q_nxt       = din_arr[owner];
                q_valid_nxt = 1'b1;
            end
            default: ;
        endcase

        if (held) begin
            state_nxt = LOCKED;
        end else if (win_found) begin
            state_nxt = GRANT;
            gnt_nxt   = N'(1) << win;
            owner_nxt = win;
            ptr_nxt   = (win == IDW'(N - 1)) ? '0 : IDW'(win + IDW'(1));
        end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt     <= '0;
            owner   <= '0;
            ptr     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            gnt     <= gnt_nxt;
            owner   <= owner_nxt;
            ptr     <= ptr_nxt;
            q       <= q_nxt;
            q_valid <= q_valid_nxt;
        end
    end

endmodule

// File: tb/tb_dreg_arbiter.sv
// Randomized and directed bench for dreg_arbiter against an index-based reference model.
module tb_dreg_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned IDW = $clog2(N);
`ifdef DREG_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] din;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] owner;
    logic [W-1:0]   q;
    logic           q_valid;

    int tests = 0;
    int fails = 0;

    // Reference model: grantee index (-1 = none), owner, rotating start point, register.
    int m_g, m_owner, m_ptr, m_q, m_qv;

    dreg_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .din(din),
        .gnt(gnt), .owner(owner), .q(q), .q_valid(q_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int din_of(input int i);
        logic [W-1:0] v;
        v = din[i*W +: W];
        return int'(v);
    endfunction

    task automatic model_reset();
        m_g = -1; m_owner = 0; m_ptr = 0; m_q = 0; m_qv = 0;
    endtask

    // One clock edge of the arbiter as described by its rules.
    task automatic model_step();
        bit active, hold, found;
        int w;
        active = (m_g >= 0);
        if (active) begin
            m_q  = din_of(m_owner);
            m_qv = 1;
        end else begin
            m_qv = 0;
        end
        hold = LOCK_EN && active && lock[m_owner];
        if (!hold) begin
            found = 0;
            w     = 0;
            for (int k = 0; k < int'(N); k++) begin
                int c;
                c = (m_ptr + k) % int'(N);
                if (!found && req[c] && c != m_g) begin
                    found = 1;
                    w     = c;
                end
            end
            if (found) begin
                m_g = w; m_owner = w; m_ptr = (w + 1) % int'(N);
            end else begin
                m_g = -1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        int eg;
        eg = (m_g < 0) ? 0 : (1 << m_g);
        check({tag, " gnt"},     32'(gnt),     32'(eg));
        check({tag, " owner"},   32'(owner),   32'(m_owner));
        check({tag, " q"},       32'(q),       32'(m_q));
        check({tag, " q_valid"}, 32'(q_valid), 32'(m_qv));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        #1 rst = 1'b1;
        model_reset();
        #1 compare_all(tag);
        #1 rst = 1'b0;
    endtask

    task automatic set_din(input int i, input logic [W-1:0] v);
        din[i*W +: W] = v;
    endtask

    initial begin
        rst = 1'b1; req = '0; lock = '0; din = '0;
        model_reset();
        #3 compare_all("reset");
        #4 rst = 1'b0;
        tick("idle");

        // Reset in the middle of a grant.
        req = 4'b0010; set_din(1, 8'hA5);
        tick("pre_rst");
        check("pre_rst gnt1", 32'(gnt), 32'h2);
        do_reset("mid_rst");
        check("mid_rst q0", 32'(q), 32'h0);
        tick("post_rst1");
        req = '0;
        tick("post_rst2");
        check("post_rst qA5", 32'(q), 32'hA5);
        tick("post_rst3");

        // Single request, then an idle gap.
        req = 4'b0100; set_din(2, 8'h3C);
        tick("single");
        check("single gnt", 32'(gnt), 32'h4);
        check("single owner", 32'(owner), 32'd2);
        req = '0;
        tick("single_wr");
        check("single q", 32'(q), 32'h3C);
        check("single qv", 32'(q_valid), 32'd1);
        tick("gap");
        check("gap q hold", 32'(q), 32'h3C);
        check("gap qv", 32'(q_valid), 32'd0);
        check("gap owner", 32'(owner), 32'd2);

        // Full contention from ptr = 0.
        do_reset("rst2");
        req = 4'b1111;
        for (int i = 0; i < int'(N); i++) set_din(i, W'(8'h10 * (i + 1)));
        for (int i = 0; i < 5; i++) begin
            tick("contend");
            check("contend owner", 32'(owner), 32'(i % int'(N)));
        end
        req = 4'b0100;
        tick("to_ptr3");
        req = '0;
        tick("drain1");
        tick("drain2");

        // Wrap: ptr = 3, then requesters 3 and 0.
        req = 4'b1001;
        tick("wrap1");
        check("wrap1 owner", 32'(owner), 32'd3);
        tick("wrap2");
        check("wrap2 owner", 32'(owner), 32'd0);
        req = '0;
        tick("wrap_gap");
        req = 4'b1111;
        tick("wrap_ptr");
        check("wrap ptr1", 32'(owner), 32'd1);
        req = '0;
        tick("wrap_end");
        tick("wrap_end2");

`ifdef DREG_ARB_LOCK_EN
        req = 4'b0010; lock = 4'b0010;
        tick("lock_g");
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            set_din(1, W'(8'hC0 + i));
            tick("lock_hold");
            check("lock gnt", 32'(gnt), 32'h2);
            check("lock q", 32'(q), 32'(8'hC0 + i));
        end
        lock = '0;
        tick("lock_rel");
        check("lock_rel gnt", 32'(gnt), 32'h1);
        req = '0;
        tick("lock_end");
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 1500; n++) begin
            req  = N'($urandom);
            lock = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            for (int i = 0; i < int'(N); i++) set_din(i, W'($urandom));
            if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dreg_arbiter.md
# dreg_arbiter

Round-robin arbiter that shares one W-bit data register (a bank of posedge D flip-flops) among N requesters. Each requester presents its data and raises a request. The arbiter grants one requester at a time and writes that requester's data into the shared register. It sits between the requesting datapath blocks and the register bank, and replaces ad-hoc muxing in front of the flip-flops.

## Interface
Parameters:
- N, 4, number of requesters (N >= 2)
- W, 8, data width of the shared register
- IDW, $clog2(N), width of the owner id (derived; not overridden)

Ports:
- clk  input  1  clock; all state changes on posedge clk
- rst  input  1  reset, asynchronous, active-high
- req  input  N  request per requester; bit i belongs to requester i
- lock  input  N  hold-grant request per requester; used only with DREG_ARB_LOCK_EN
- din  input  N*W  requester data; requester i uses din[i*W +: W]
- gnt  output  N  registered one-hot grant, or all zero
- owner  output  IDW  index of the current or most recent grantee
- q  output  W  shared register contents
- q_valid  output  1  one-cycle pulse: q was written at the preceding edge

## Operation
- States:
  - IDLE: no grant.
  - GRANT: single-cycle grant.
  - LOCKED: held grant; only with the macro.
- Eligible set E = req & ~gnt. The current grantee's request is masked during its own grant cycle.
- Winner w: the first i with E[i]=1, searching ptr, ptr+1, … and wrapping mod N.
- Arbitration is evaluated in IDLE, and in GRANT when the grant is not being held. At the edge:
  - If E is not zero: gnt<=onehot(w), owner<=w, ptr<=(w+1) mod N, state<=GRANT.
  - If E is zero: gnt<=0, state<=IDLE. owner and ptr hold.
- Write rule: at every edge where state is GRANT or LOCKED:
  - q <= din[owner*W +: W] and q_valid<=1.
  - Otherwise q holds and q_valid<=0.
- Handshake:
  - Requester i keeps req[i] high until it sees gnt[i]=1.
  - It drops req[i] in the cycle after that.
  - req[i] still high after its grant cycle counts as a new request at the lowest round-robin priority.
- din of the grantee must be stable during its grant cycle. din of non-grantees is ignored.
- Round-robin wrap: after granting N-1, ptr=0.
- Simultaneous requests are granted in ptr order, one per cycle, back-to-back with no idle cycle in between.

## Timing
- Reset values: gnt=0, owner=0, q=0, q_valid=0, ptr=0, state=IDLE.
- Latency:
  - req sampled high at edge k gives gnt at cycle k..k+1.
  - q is updated and q_valid=1 after edge k+1.
  - Request to data in register: 2 edges.
- Throughput: one write per cycle while requests are pending.
- Reset mid-grant: the grant is dropped immediately and no write occurs; q returns to 0.
- A req that falls before it is sampled is never granted. The block does not latch requests.
- owner is stable from the edge that raises gnt until the next grant.

## Configuration
- DREG_ARB_LOCK_EN defined:
  - In GRANT or LOCKED, if lock[owner]=1 at the edge, state<=LOCKED and gnt holds.
  - The register is rewritten from din[owner] every cycle, with q_valid=1 every cycle.
  - While held, the arbitration masking and ptr update are suspended.
  - When lock[owner]=0 at the edge, the current cycle's write still occurs and normal arbitration resumes at that edge.
  - Lock on a non-owner is ignored.
- DREG_ARB_LOCK_EN undefined:
  - The lock port exists but is ignored.
  - LOCKED is unreachable and every grant lasts exactly one cycle.

## Test plan
- Reset: assert rst mid-grant with req=4'b0010 and din[1]=8'hA5 -> gnt=0 and q=0 immediately; after release and 2 edges, q=8'hA5.
- Single request: req=4'b0100 for 1 cycle with din[2]=8'h3C -> gnt=4'b0100 for 1 cycle, owner=2, next cycle q=8'h3C with a 1-cycle q_valid pulse.
- Contention: req=4'b1111 held with distinct din values -> grants in order 0,1,2,3,0 on consecutive cycles; q follows one cycle behind; q_valid stays high.
- Wrap and fairness: ptr at 3, then req=4'b1001 -> gnt to 3 first, then 0; ptr=1 afterwards.
- Idle gap: req falls to 0 after a grant -> gnt=0, q holds its last value, q_valid=0, owner unchanged.
- Lock (DREG_ARB_LOCK_EN only): requester 1 granted with lock[1]=1 for 3 cycles while req[0]=1 -> gnt stays 4'b0010 and q tracks din[1] each cycle; on lock release, requester 0 is granted on the following edge.
